// File: rtl/fp_arbiter.sv
// Shares one fixed-latency FPU among NREQ requesters, then routes each result back to its issuer.
// Define FP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); the default is round-robin.
module fp_arbiter #(
  parameter int NREQ    = 3,
  parameter int FPU_LAT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 fpu_start,
  output logic [1:0]           fpu_op,
  output logic [31:0]          fpu_a,
  output logic [31:0]          fpu_b,
  input  logic [31:0]          fpu_result,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  input  logic                 flush,
  output logic                 busy
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LAST = FPU_LAT - 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state_q;

  logic [NREQ-1:0] gnt_oh;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            grant_en;
  logic            accept;

  logic [1:0]      sel_op;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;

  logic            fpu_start_q;
  logic [1:0]      fpu_op_q;
  logic [31:0]     fpu_a_q;
  logic [31:0]     fpu_b_q;
  logic [IW-1:0]   issue_tag_q;

  logic [FPU_LAT-1:0] slot_vld_q;
  logic [IW-1:0]      slot_tag_q [FPU_LAT];

  logic [NREQ-1:0] rsp_oh;
  logic [NREQ-1:0] rsp_valid_q;
  logic [31:0]     rsp_data_q;
  logic            busy_w;

`ifdef FP_ARB_FIXED_PRIO_EN
  // Scan from the top so the lowest valid index is the last one written.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_oh    = '0;
        gnt_oh[k] = 1'b1;
        gnt_idx   = IW'(k);
        gnt_any   = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  int            cand;

  // Walk from the farthest offset back to the pointer so the nearest valid requester wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (req_valid[cand]) begin
        gnt_oh       = '0;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = IW'(cand);
        gnt_any      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Reset gates the grant combinationally so req_ready drops the moment reset asserts.
  assign grant_en  = reset && (state_q == RUN) && !flush;
  assign req_ready = grant_en ? gnt_oh : '0;
  assign accept    = grant_en && gnt_any;

  always_comb begin
    sel_op = req_op[2*int'(gnt_idx) +: 2];
    sel_a  = req_a[32*int'(gnt_idx) +: 32];
    sel_b  = req_b[32*int'(gnt_idx) +: 32];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpu_start_q <= 1'b0;
      fpu_op_q    <= 2'b00;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      issue_tag_q <= '0;
    end else begin
      fpu_start_q <= accept;
      if (accept) begin
        fpu_op_q    <= sel_op;
        fpu_a_q     <= sel_a;
        fpu_b_q     <= sel_b;
        issue_tag_q <= gnt_idx;
      end
    end
  end

  // Slot k holds the issuer of the operation that started k+1 cycles ago.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_vld_q <= '0;
      for (int k = 0; k < FPU_LAT; k++) begin
        slot_tag_q[k] <= '0;
      end
    end else begin
      slot_vld_q[0] <= fpu_start_q;
      slot_tag_q[0] <= issue_tag_q;
      for (int k = 1; k < FPU_LAT; k++) begin
        slot_vld_q[k] <= slot_vld_q[k-1];
        slot_tag_q[k] <= slot_tag_q[k-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rsp_route
      assign rsp_oh[gi] = slot_vld_q[LAST] && (slot_tag_q[LAST] == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_oh;
      if (slot_vld_q[LAST]) begin
        rsp_data_q <= fpu_result;
      end
    end
  end

  assign busy_w = fpu_start_q || (|slot_vld_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!busy_w) begin
            state_q <= flush ? HALT : RUN;
          end
        end
        HALT: begin
          if (!flush) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign fpu_start = fpu_start_q;
  assign fpu_op    = fpu_op_q;
  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_w;

endmodule

// File: tb/tb_fp_arbiter.sv
// Directed bench for fp_arbiter with a fixed-latency FPU stub and an in-order response scoreboard.
module tb_fp_arbiter;

  localparam int NREQ    = 3;
  localparam int FPU_LAT = 4;
`ifdef FP_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [2*NREQ-1:0]    req_op = '0;
  logic [32*NREQ-1:0]   req_a = '0;
  logic [32*NREQ-1:0]   req_b = '0;
  logic                 fpu_start;
  logic [1:0]           fpu_op;
  logic [31:0]          fpu_a;
  logic [31:0]          fpu_b;
  logic [31:0]          fpu_result;
  logic [NREQ-1:0]      rsp_valid;
  logic [31:0]          rsp_data;
  logic                 flush = 1'b0;
  logic                 busy;

  fp_arbiter #(.NREQ(NREQ), .FPU_LAT(FPU_LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_result(fpu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit sb_en = 1'b0;
  bit hold_ops = 1'b0;

  logic [2:0]  prev_gnt = '0;
  logic [1:0]  prev_op = '0;
  logic [31:0] prev_a = '0;
  logic [31:0] prev_b = '0;

  typedef struct {
    int          due;
    logic [2:0]  oh;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  function automatic logic [31:0] fpu_f(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    if (op == 2'b00 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
  endfunction

  // FPU stub: result of the op started in cycle S is presented during cycle S+FPU_LAT.
  logic [31:0] fpu_pipe [FPU_LAT];
  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_start ? fpu_f(fpu_a, fpu_b, fpu_op) : 32'd0;
    for (int k = 1; k < FPU_LAT; k++) fpu_pipe[k] <= fpu_pipe[k-1];
  end
  assign fpu_result = fpu_pipe[FPU_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every cycle, rsp_valid is either the next due response or zero.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (sb_en) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
          check("rsp_valid", {29'd0, rsp_valid}, {29'd0, sb_q[0].oh});
          check("rsp_data", rsp_data, sb_q[0].data);
          $display("rsp: cycle %0d valid %b data %h", cyc, rsp_valid, rsp_data);
          void'(sb_q.pop_front());
        end else begin
          check("rsp_idle", {29'd0, rsp_valid}, 32'd0);
        end
      end
    end
  end

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32]  = 32'h4000_0000 | (32'(i) << 16) | (32'(cyc) & 32'h0000_FFFF);
      req_b[i*32 +: 32]  = 32'hC000_0000 | (32'(i) << 16) | (~32'(cyc) & 32'h0000_FFFF);
      req_op[i*2 +: 2]   = 2'(i + cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  {29'd0, req_ready}, 32'd0);
    check({tag, "_start"},  {31'd0, fpu_start}, 32'd0);
    check({tag, "_op"},     {30'd0, fpu_op},    32'd0);
    check({tag, "_a"},      fpu_a,              32'd0);
    check({tag, "_b"},      fpu_b,              32'd0);
    check({tag, "_rspv"},   {29'd0, rsp_valid}, 32'd0);
    check({tag, "_rspd"},   rsp_data,           32'd0);
    check({tag, "_busy"},   {31'd0, busy},      32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb_en = 1'b0;
    sb_q.delete();
    prev_gnt = '0;
    req_valid = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("rst");
    #1;
    reset = 1'b1;
    sb_en = 1'b1;
  endtask

  // One clock cycle: check last cycle's issue, drive inputs, check grant and busy, log a transfer.
  task automatic cyc_step(input logic [2:0] v, input logic fl, input logic [2:0] exp_rdy, input int exp_busy);
    int idx;
    exp_t e;
    @(posedge clk);
    #1;
    if (prev_gnt != 3'b000) begin
      check("fpu_start", {31'd0, fpu_start}, 32'd1);
      check("fpu_op", {30'd0, fpu_op}, {30'd0, prev_op});
      check("fpu_a", fpu_a, prev_a);
      check("fpu_b", fpu_b, prev_b);
    end else begin
      check("fpu_start_idle", {31'd0, fpu_start}, 32'd0);
    end
    if (!hold_ops) set_ops();
    req_valid = v;
    flush = fl;
    #1;
    check("req_ready", {29'd0, req_ready}, {29'd0, exp_rdy});
    if (exp_busy >= 0) check("busy", {31'd0, busy}, 32'(exp_busy));
    prev_gnt = exp_rdy;
    if (exp_rdy != 3'b000) begin
      idx = exp_rdy[0] ? 0 : (exp_rdy[1] ? 1 : 2);
      prev_op = req_op[idx*2 +: 2];
      prev_a  = req_a[idx*32 +: 32];
      prev_b  = req_b[idx*32 +: 32];
      e.due  = cyc + FPU_LAT + 2;
      e.oh   = exp_rdy;
      e.data = fpu_f(prev_a, prev_b, prev_op);
      sb_q.push_back(e);
      $display("txn: cycle %0d grant req%0d op %0d a %h b %h", cyc, idx, prev_op, prev_a, prev_b);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_step(3'b000, 1'b0, 3'b000, -1);
  endtask

  initial begin
    do_reset();

    // Single add: accept at T, issue at T+1, response at T+6.
    hold_ops = 1'b1;
    req_op = '0;
    req_a  = {64'd0, 32'h3F80_0000};
    req_b  = {64'd0, 32'h4000_0000};
    cyc_step(3'b001, 1'b0, 3'b001, 0);
    for (int i = 0; i < 5; i++) cyc_step(3'b000, 1'b0, 3'b000, 1);
    cyc_step(3'b000, 1'b0, 3'b000, 0);
    check("add_rspv", {29'd0, rsp_valid}, 32'd1);
    check("add_rspd", rsp_data, 32'h4040_0000);
    hold_ops = 1'b0;
    idle(2);

    // Three requesters continuously valid from reset.
    do_reset();
    cyc_step(3'b111, 1'b0, 3'b001, -1);
    cyc_step(3'b111, 1'b0, FIXED ? 3'b001 : 3'b010, -1);
    cyc_step(3'b111, 1'b0, FIXED ? 3'b001 : 3'b100, -1);
    cyc_step(3'b111, 1'b0, 3'b001, -1);
    cyc_step(3'b111, 1'b0, FIXED ? 3'b001 : 3'b010, -1);
    cyc_step(3'b111, 1'b0, FIXED ? 3'b001 : 3'b100, -1);
    idle(8);

    // Flush with three operations in flight, then resume from the preserved pointer.
    cyc_step(3'b111, 1'b0, 3'b001, 0);
    cyc_step(3'b111, 1'b0, FIXED ? 3'b001 : 3'b010, 1);
    cyc_step(3'b011, 1'b0, 3'b001, 1);
    for (int i = 0; i < 5; i++) cyc_step(3'b111, 1'b1, 3'b000, 1);
    cyc_step(3'b111, 1'b1, 3'b000, 0);
    cyc_step(3'b111, 1'b1, 3'b000, 0);
    cyc_step(3'b111, 1'b0, 3'b000, 0);
    cyc_step(3'b111, 1'b0, FIXED ? 3'b001 : 3'b010, 0);
    cyc_step(3'b111, 1'b0, FIXED ? 3'b001 : 3'b100, 1);
    idle(8);

    // Requesters 0 and 2 continuously valid.
    for (int i = 0; i < 4; i++)
      cyc_step(3'b101, 1'b0, (FIXED || (i % 2 == 0)) ? 3'b001 : 3'b100, -1);
    idle(8);

    // One-cycle flush on an empty pipeline: no grant in the flush and drain cycles only.
    cyc_step(3'b111, 1'b1, 3'b000, 0);
    cyc_step(3'b111, 1'b0, 3'b000, 0);
    cyc_step(3'b111, 1'b0, 3'b001, 0);
    cyc_step(3'b111, 1'b0, FIXED ? 3'b001 : 3'b010, 1);
    idle(8);

    // Reset pulse with two operations in flight.
    cyc_step(3'b111, 1'b0, FIXED ? 3'b001 : 3'b100, -1);
    cyc_step(3'b111, 1'b0, 3'b001, -1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_en = 1'b0;
    sb_q.delete();
    prev_gnt = '0;
    #1;
    check_all_zero("async");
    @(posedge clk);
    #1;
    check_all_zero("held");
    req_valid = '0;
    reset = 1'b1;
    sb_en = 1'b1;
    for (int i = 0; i < 10; i++) cyc_step(3'b000, 1'b0, 3'b000, 0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
